// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg -- shared constants for the SD-card SPI-mode responder.
//   Command indices, R1 status bit positions, control-state encodings,
//   the decoded-response record and an R1 builder helper.
package sd_spi_pkg;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [5:0] CMD58 = 6'd58;

    localparam int R1_IDLE    = 0;
    localparam int R1_ILLEGAL = 2;
    localparam int R1_CRC_ERR = 3;

    localparam logic [1:0] ST_WAIT_CMD = 2'd0;
    localparam logic [1:0] ST_RX_CMD   = 2'd1;
    localparam logic [1:0] ST_NCR      = 2'd2;
    localparam logic [1:0] ST_TX_RESP  = 2'd3;

    localparam logic [7:0] FILL_BYTE = 8'hFF;

    // R1 byte plus optional 4-byte tail (R7 echo or OCR)
    typedef struct packed {
        logic [7:0]  r1;
        logic [31:0] tail;
        logic        has_tail;
    } resp_t;

    function automatic logic [7:0] r1_byte(input logic idle, input logic illegal,
                                           input logic crc_err);
        logic [7:0] r;
        r             = '0;
        r[R1_IDLE]    = idle;
        r[R1_ILLEGAL] = illegal;
        r[R1_CRC_ERR] = crc_err;
        return r;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// sd_crc7 -- one-byte step of the SD command CRC7 (x^7 + x^3 + 1), MSB first.
//   crc_i  : running remainder before this byte (0 at frame start)
//   data_i : next frame byte
//   crc_o  : remainder after this byte
module sd_crc7 (
    input  logic [6:0] crc_i,
    input  logic [7:0] data_i,
    output logic [6:0] crc_o
);

    always_comb begin
        logic [6:0] c;
        logic       fb;
        c = crc_i;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data_i[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        crc_o = c;
    end

endmodule

// File: rtl/sd_spi_responder.sv
// sd_spi_responder -- minimal SD-card SPI-mode command responder.
//   Receives 6-byte command frames from an SPI mode-0 host, pulses cmd_valid,
//   and after NCR_BYTES of 0xFF fill returns R1 / R7 / R3 style responses for
//   CMD0, CMD8, CMD55, ACMD41 and CMD58; anything else gets R1 "illegal".
//   Ports:
//     clk, rst      system clock (>= 8x spi_clk), synchronous active-high reset
//     spi_clk/cs/di host SPI inputs, asynchronous, synchronised internally
//     spi_do        MISO, idles high
//     cmd_valid     one-clk pulse per accepted frame
//     cmd_index/arg fields of the last accepted frame
//     card_idle     R1 idle bit currently reported
//   Build option: SD_RESPONDER_CRC_CHECK_EN enables CRC7 checking of frames.
module sd_spi_responder
    import sd_spi_pkg::*;
#(
    parameter int          NCR_BYTES   = 1,
    parameter int          ACMD41_BUSY = 2,
    parameter logic [31:0] OCR         = 32'hC0FF8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_clk,
    input  logic        spi_cs,
    input  logic        spi_di,
    output logic        spi_do,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        card_idle
);

    localparam int BW = (ACMD41_BUSY > 1) ? $clog2(ACMD41_BUSY + 1) : 1;

    // ---- input synchronisers; sclk_q[2] is the previous synced sample ----
    logic [2:0] sclk_q;
    logic [1:0] cs_q, di_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            cs_q   <= 2'b11;
            di_q   <= 2'b11;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_clk};
            cs_q   <= {cs_q[0], spi_cs};
            di_q   <= {di_q[0], spi_di};
        end
    end

    logic rise, fall, cs_hi, di_s;
    assign rise  = sclk_q[1] & ~sclk_q[2];
    assign fall  = ~sclk_q[1] & sclk_q[2];
    assign cs_hi = cs_q[1];
    assign di_s  = di_q[1];

    // ---- state ----
    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    sr_q, sr_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [37:0]   cmd_sr_q, cmd_sr_d;   // index(6) + arg(32); byte0 top bits fall off
    logic [2:0]    ncr_q, ncr_d;
    logic [7:0]    tx_q, tx_d;           // byte currently being shifted out
    logic [39:0]   resp_q, resp_d;       // queued response bytes, MSB byte next
    logic [2:0]    resp_left_q, resp_left_d;
    logic          spi_do_q, spi_do_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [5:0]    cmd_index_q, cmd_index_d;
    logic [31:0]   cmd_arg_q, cmd_arg_d;
    logic          idle_q, idle_d;
    logic          app_q, app_d;
    logic [BW-1:0] busy_q, busy_d;

    logic [7:0] rx_byte;
    logic       byte_done;
    assign rx_byte   = {sr_q, di_s};
    assign byte_done = rise & ~cs_hi & (bit_cnt_q == 3'd7);

    // ---- optional CRC7 check over bytes 0..4 ----
    logic crc_err;
`ifdef SD_RESPONDER_CRC_CHECK_EN
    logic [6:0] crc_q, crc_d, crc_seed, crc_next;
    assign crc_seed = (state_q == ST_WAIT_CMD) ? 7'd0 : crc_q;

    sd_crc7 u_crc7 (
        .crc_i  (crc_seed),
        .data_i (rx_byte),
        .crc_o  (crc_next)
    );

    always_comb begin
        crc_d = crc_q;
        if (byte_done && (state_q == ST_WAIT_CMD || state_q == ST_RX_CMD))
            crc_d = crc_next;
    end

    always_ff @(posedge clk) begin
        if (rst) crc_q <= '0;
        else     crc_q <= crc_d;
    end

    // only consulted when the CRC byte (byte 5) completes
    assign crc_err = (rx_byte[7:1] != crc_q);
`else
    assign crc_err = 1'b0;
`endif

    // ---- command decode: next card state and response for the held frame ----
    logic [5:0]    idx;
    logic [31:0]   arg;
    logic          idle_n, app_n, illegal;
    logic [BW-1:0] busy_n;
    resp_t         resp;

    assign idx = cmd_sr_q[37:32];
    assign arg = cmd_sr_q[31:0];

    always_comb begin
        idle_n        = idle_q;
        app_n         = 1'b0;
        busy_n        = busy_q;
        illegal       = 1'b0;
        resp.tail     = '0;
        resp.has_tail = 1'b0;
        case (idx)
            CMD0: begin
                idle_n = 1'b1;
                busy_n = BW'(ACMD41_BUSY);
            end
            CMD8: begin
                resp.tail     = arg;
                resp.has_tail = 1'b1;
            end
            CMD55: app_n = 1'b1;
            CMD41: begin
                if (!app_q)               illegal = 1'b1;
                else if (busy_q != '0)    busy_n  = busy_q - BW'(1);
                else                      idle_n  = 1'b0;
            end
            CMD58: begin
                resp.tail     = OCR;
                resp.has_tail = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        // a corrupted frame leaves the card state untouched
        if (crc_err) begin
            idle_n        = idle_q;
            app_n         = app_q;
            busy_n        = busy_q;
            illegal       = 1'b0;
            resp.has_tail = 1'b0;
        end
        resp.r1 = r1_byte(idle_n, illegal, crc_err);
    end

    // ---- byte engine / control FSM ----
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        rx_idx_d    = rx_idx_q;
        cmd_sr_d    = cmd_sr_q;
        ncr_d       = ncr_q;
        tx_d        = tx_q;
        resp_d      = resp_q;
        resp_left_d = resp_left_q;
        spi_do_d    = spi_do_q;
        cmd_valid_d = 1'b0;
        cmd_index_d = cmd_index_q;
        cmd_arg_d   = cmd_arg_q;
        idle_d      = idle_q;
        app_d       = app_q;
        busy_d      = busy_q;

        if (cs_hi) begin
            // deselect aborts any frame or response in flight
            state_d   = ST_WAIT_CMD;
            bit_cnt_d = '0;
            rx_idx_d  = '0;
            tx_d      = FILL_BYTE;
            spi_do_d  = 1'b1;
        end else begin
            if (rise) begin
                sr_d      = {sr_q[5:0], di_s};
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            // after the 8th rise bit_cnt wraps to 0, so the falling edge that
            // closes a byte already presents the MSB of the next one
            if (fall) spi_do_d = tx_q[~bit_cnt_q];

            if (byte_done) begin
                tx_d = FILL_BYTE;
                case (state_q)
                    ST_WAIT_CMD: begin
                        if (rx_byte[7:6] == 2'b01) begin
                            cmd_sr_d = {cmd_sr_q[29:0], rx_byte};
                            rx_idx_d = 3'd1;
                            state_d  = ST_RX_CMD;
                        end
                    end
                    ST_RX_CMD: begin
                        if (rx_idx_q == 3'd5) begin
                            cmd_valid_d = 1'b1;
                            cmd_index_d = idx;
                            cmd_arg_d   = arg;
                            idle_d      = idle_n;
                            app_d       = app_n;
                            busy_d      = busy_n;
                            resp_d      = {resp.r1, resp.tail};
                            resp_left_d = resp.has_tail ? 3'd4 : 3'd0;
                            ncr_d       = 3'(NCR_BYTES - 1);
                            state_d     = ST_NCR;
                        end else begin
                            cmd_sr_d = {cmd_sr_q[29:0], rx_byte};
                            rx_idx_d = rx_idx_q + 3'd1;
                        end
                    end
                    ST_NCR: begin
                        if (ncr_q == 3'd0) begin
                            tx_d    = resp_q[39:32];
                            resp_d  = {resp_q[31:0], FILL_BYTE};
                            state_d = ST_TX_RESP;
                        end else begin
                            ncr_d = ncr_q - 3'd1;
                        end
                    end
                    default: begin
                        if (resp_left_q == 3'd0) begin
                            state_d = ST_WAIT_CMD;
                        end else begin
                            tx_d        = resp_q[39:32];
                            resp_d      = {resp_q[31:0], FILL_BYTE};
                            resp_left_d = resp_left_q - 3'd1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT_CMD;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            rx_idx_q    <= '0;
            cmd_sr_q    <= '0;
            ncr_q       <= '0;
            tx_q        <= FILL_BYTE;
            resp_q      <= '1;
            resp_left_q <= '0;
            spi_do_q    <= 1'b1;
            cmd_valid_q <= 1'b0;
            cmd_index_q <= '0;
            cmd_arg_q   <= '0;
            idle_q      <= 1'b1;
            app_q       <= 1'b0;
            busy_q      <= BW'(ACMD41_BUSY);
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            rx_idx_q    <= rx_idx_d;
            cmd_sr_q    <= cmd_sr_d;
            ncr_q       <= ncr_d;
            tx_q        <= tx_d;
            resp_q      <= resp_d;
            resp_left_q <= resp_left_d;
            spi_do_q    <= spi_do_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_index_q <= cmd_index_d;
            cmd_arg_q   <= cmd_arg_d;
            idle_q      <= idle_d;
            app_q       <= app_d;
            busy_q      <= busy_d;
        end
    end

    assign spi_do    = spi_do_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_index = cmd_index_q;
    assign cmd_arg   = cmd_arg_q;
    assign card_idle = idle_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// tb_sd_spi_responder -- directed + randomised bench for sd_spi_responder.
//   Acts as an SPI mode-0 host; expected responses come from a byte-level
//   model of the SD SPI init protocol kept in this file.
module tb_sd_spi_responder;

    localparam int          NCR  = 1;
    localparam int          BUSY = 2;
    localparam logic [31:0] OCRV = 32'hC0FF8000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_di = 1'b1;
    logic        spi_do;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        card_idle;

    sd_spi_responder #(.NCR_BYTES(NCR), .ACMD41_BUSY(BUSY), .OCR(OCRV)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_clk   (spi_clk),
        .spi_cs    (spi_cs),
        .spi_di    (spi_di),
        .spi_do    (spi_do),
        .cmd_valid (cmd_valid),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
        .card_idle (card_idle)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int half   = 50;
    int cv_cnt = 0;
    int exp_cv = 0;

    // model of the card
    bit          m_idle = 1'b1;
    bit          m_app  = 1'b0;
    int          m_busy = BUSY;
    logic [5:0]  m_index = '0;
    logic [31:0] m_arg   = '0;

    always @(negedge clk) if (!rst && cmd_valid) cv_cnt++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // CRC7 as polynomial long division of M(x)*x^7 by x^7+x^3+1
    function automatic logic [6:0] crc7_ref(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [47:0] mk(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b01, idx, arg};
        return {m, crc7_ref(m), 1'b1};
    endfunction

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_di = tx[i];
            #(half);
            rx[i]   = spi_do;
            spi_clk = 1'b1;
            #(half);
            spi_clk = 1'b0;
        end
    endtask

    // full transaction; cut >= 0 deselects after that many response bytes
    task automatic do_cmd(input string tag, input logic [47:0] fr, input int cut);
        logic [7:0] rx;
        logic [7:0] exp_q[$];
        logic [5:0] idx;
        logic [31:0] arg;
        bit crc_ok;
        int n;
        half = 10 * $urandom_range(5, 7);
        idx  = fr[45:40];
        arg  = fr[39:8];
        crc_ok = 1'b1;
`ifdef SD_RESPONDER_CRC_CHECK_EN
        crc_ok = (crc7_ref(fr[47:8]) == fr[7:1]);
`endif
        for (int k = 0; k < NCR; k++) exp_q.push_back(8'hFF);
        if (!crc_ok) begin
            exp_q.push_back(8'h08 | {7'b0, m_idle});
        end else begin
            if (idx == 6'd0) begin
                m_idle = 1'b1; m_busy = BUSY; m_app = 1'b0;
                exp_q.push_back(8'h01);
            end else if (idx == 6'd8) begin
                m_app = 1'b0;
                exp_q.push_back({7'b0, m_idle});
                for (int k = 3; k >= 0; k--) exp_q.push_back(arg[8*k +: 8]);
            end else if (idx == 6'd55) begin
                m_app = 1'b1;
                exp_q.push_back({7'b0, m_idle});
            end else if (idx == 6'd41 && m_app) begin
                m_app = 1'b0;
                if (m_busy > 0) m_busy--;
                else            m_idle = 1'b0;
                exp_q.push_back({7'b0, m_idle});
            end else if (idx == 6'd58) begin
                m_app = 1'b0;
                exp_q.push_back({7'b0, m_idle});
                for (int k = 3; k >= 0; k--) exp_q.push_back(OCRV[8*k +: 8]);
            end else begin
                m_app = 1'b0;
                exp_q.push_back(8'h04 | {7'b0, m_idle});
            end
        end
        m_index = idx;
        m_arg   = arg;
        exp_cv++;

        spi_cs = 1'b0;
        #(half);
        for (int b = 0; b < 6; b++) begin
            xfer(fr[47 - 8*b -: 8], rx);
            chk($sformatf("%s/miso_during_cmd%0d", tag, b), rx, 8'hFF);
        end
        n = (cut < 0) ? exp_q.size() : NCR + cut;
        for (int k = 0; k < n; k++) begin
            xfer(8'hFF, rx);
            chk($sformatf("%s/resp%0d", tag, k), rx, exp_q[k]);
        end
        if (cut < 0) begin
            xfer(8'hFF, rx);
            chk({tag, "/after_resp"}, rx, 8'hFF);
        end
        #(half);
        spi_cs = 1'b1;
        #(2*half);
        chk({tag, "/cmd_valid_count"}, cv_cnt, exp_cv);
        chk({tag, "/cmd_index"}, cmd_index, m_index);
        chk({tag, "/cmd_arg"}, cmd_arg, m_arg);
        chk({tag, "/card_idle"}, card_idle, m_idle);
        chk({tag, "/miso_deselected"}, spi_do, 1'b1);
    endtask

    // send only the first nbytes of a frame, then deselect
    task automatic abort_cmd(input string tag, input logic [47:0] fr, input int nbytes);
        logic [7:0] rx;
        half = 50;
        spi_cs = 1'b0;
        #(half);
        for (int b = 0; b < nbytes; b++) xfer(fr[47 - 8*b -: 8], rx);
        #(half);
        spi_cs = 1'b1;
        #(2*half);
        chk({tag, "/cmd_valid_count"}, cv_cnt, exp_cv);
        chk({tag, "/card_idle"}, card_idle, m_idle);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rx;
        logic [5:0]  ridx;
        logic [31:0] rarg;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset/spi_do", spi_do, 1'b1);
        chk("reset/cmd_valid", cmd_valid, 1'b0);
        chk("reset/cmd_index", cmd_index, 6'd0);
        chk("reset/cmd_arg", cmd_arg, 32'd0);
        chk("reset/card_idle", card_idle, 1'b1);

        // power-up clocks with card deselected
        for (int i = 0; i < 10; i++) begin
            xfer(8'hFF, rx);
            chk("powerup/miso", rx, 8'hFF);
        end
        chk("powerup/cmd_valid_count", cv_cnt, 0);

        do_cmd("cmd0", 48'h40_00_00_00_00_95, -1);
        do_cmd("cmd8", 48'h48_00_00_01_AA_87, -1);
        rarg = $urandom;
        do_cmd("cmd8_rand", mk(6'd8, rarg), -1);

        for (int i = 0; i < 3; i++) begin
            do_cmd($sformatf("cmd55_%0d", i), mk(6'd55, 32'h0), -1);
            do_cmd($sformatf("acmd41_%0d", i), mk(6'd41, 32'h40000000), -1);
        end
        chk("init/card_idle", card_idle, 1'b0);
        do_cmd("cmd58", mk(6'd58, 32'h0), -1);

        // partial CMD0 must not reset the card
        abort_cmd("abort_cmd0", 48'h40_00_00_00_00_95, 3);
        do_cmd("cmd8_after_abort", 48'h48_00_00_01_AA_87, -1);

        // deselect in the middle of a response
        do_cmd("cmd58_cut", mk(6'd58, 32'h0), 2);
        do_cmd("cmd8_after_cut", mk(6'd8, $urandom), -1);

        do_cmd("cmd0_b", mk(6'd0, 32'h0), -1);
        do_cmd("cmd17", 48'h51_00_00_00_00_FF, -1);

        for (int i = 0; i < 3; i++) begin
            do ridx = 6'($urandom_range(0, 63));
            while (ridx == 6'd0 || ridx == 6'd8 || ridx == 6'd41 ||
                   ridx == 6'd55 || ridx == 6'd58);
            do_cmd($sformatf("illegal_%0d", i), mk(ridx, $urandom), -1);
        end
        do_cmd("cmd41_no_app", mk(6'd41, 32'h40000000), -1);
        do_cmd("cmd0_badcrc", 48'h40_00_00_00_00_00, -1);
        do_cmd("cmd55_final", mk(6'd55, 32'h0), -1);
        do_cmd("acmd41_final", mk(6'd41, 32'h40000000), -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_spi_responder.md
SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 SHALL have parameter NCR_BYTES, default 1, count of 0xFF fill bytes between command end and response (1..8).
REQ-002 SHALL have parameter ACMD41_BUSY, default 2, count of ACMD41 replies with R1=0x01 before R1=0x00.
REQ-003 SHALL have parameter OCR, default 32'hC0FF8000, value returned by CMD58.
REQ-004 SHALL have port clk  input  1  system clock, at least 8x spi_clk frequency.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port spi_clk  input  1  host SPI clock, mode 0, asynchronous to clk.
REQ-007 SHALL have port spi_cs  input  1  chip select, active low.
REQ-008 SHALL have port spi_di  input  1  host-to-card data (MOSI).
REQ-009 SHALL have port spi_do  output  1  card-to-host data (MISO); 1 when not transmitting.
REQ-010 SHALL have port cmd_valid  output  1  one-clk pulse when a complete command frame is accepted.
REQ-011 SHALL have port cmd_index  output  6  index of last accepted command.
REQ-012 SHALL have port cmd_arg  output  32  argument of last accepted command.
REQ-013 SHALL have port card_idle  output  1  R1 idle bit currently reported.

Function
REQ-014 SHALL synchronise spi_clk, spi_cs, spi_di through 2 flip-flops and detect spi_clk edges on synchronised samples.
REQ-015 SHALL sample spi_di on spi_clk rising edges, MSB first, and change spi_do only on falling edges, within 4 clk of the synchronised edge.
REQ-016 SHALL hold bit counter at 0 and spi_do at 1 while spi_cs is high; bytes are aligned to first rising edge after spi_cs falls.
REQ-017 SHALL run states WAIT_CMD, RX_CMD, NCR, TX_RESP; WAIT_CMD discards bytes whose top two bits are not 01.
REQ-018 SHALL, in WAIT_CMD, treat a byte with top bits 01 as byte 0 and enter RX_CMD; after byte 5 (CRC7 plus end bit) pulse cmd_valid, update cmd_index/cmd_arg, enter NCR.
REQ-019 SHALL drive 0xFF for NCR_BYTES bytes, then enter TX_RESP; each byte's MSB appears on the falling edge ending the previous byte.
REQ-020 SHALL respond: CMD0 -> R1 0x01, sets idle and busy counter = ACMD41_BUSY; CMD8 -> R7 (R1, then 4 bytes echoing arg[31:0]); CMD55 -> R1, sets app flag; ACMD41 -> 0x01 while busy counter non-zero (decrement), else 0x00 and clear idle; CMD58 -> R1 then OCR MSB first; any other index, or CMD41 without app flag -> R1 with bit2 (0x04) set.
REQ-021 SHALL clear app flag after any command other than CMD55; R1 bit0 SHALL equal card_idle.
REQ-022 SHALL return to WAIT_CMD after last response byte; spi_do SHALL be 1 thereafter.
REQ-023 SHALL, on spi_cs rising mid-frame or mid-response, abort to WAIT_CMD without cmd_valid and without changing idle/app/busy state.
REQ-024 SHALL ignore bytes received in NCR/TX_RESP (no overlapping commands).

Reset
REQ-025 SHALL on rst set state WAIT_CMD, spi_do=1, cmd_valid=0, cmd_index=0, cmd_arg=0, card_idle=1, app flag=0, busy counter=ACMD41_BUSY, bit counter=0.
REQ-026 SHALL give rst priority over all SPI activity in the same cycle.

Configuration
REQ-027 SHALL, with macro SD_RESPONDER_CRC_CHECK_EN defined, compute CRC7 over bytes 0-4 and on mismatch with byte5[7:1] reply R1 with bit3 (0x08) set, no side-effect on idle/app/busy state.
REQ-028 SHALL, without SD_RESPONDER_CRC_CHECK_EN, ignore the CRC field and omit CRC logic.

Structure
REQ-029 SHALL place command indices, R1 bit positions and state encodings in shared package sd_spi_pkg.
REQ-030 SHALL implement CRC7 (polynomial x^7+x^3+1) in sub-module sd_crc7, instantiated only when CRC check enabled.

Verification
REQ-031 SHALL cover: 10 x 0xFF with cs high, then CMD0 40 00 00 00 00 95 -> one 0xFF, then 0x01; cmd_valid pulse, cmd_index=0.
REQ-032 SHALL cover: CMD8 48 00 00 01 AA 87 -> 0x01 00 00 01 AA.
REQ-033 SHALL cover: (CMD55, ACMD41 arg 0x40000000) x3 -> ACMD41 replies 0x01, 0x01, 0x00; card_idle=0; CMD58 -> 0x00 C0 FF 80 00.
REQ-034 SHALL cover: CMD17 51 00 00 00 00 FF -> R1 0x05 while idle.
REQ-035 SHALL cover: CMD0 with CRC 0x00 -> 0x09 with macro defined, 0x01 without.
REQ-036 SHALL cover: cs raised after 3 bytes of CMD0, then full CMD8 -> no cmd_valid for CMD0, CMD8 answered normally.
